ascon_perm_iter: RTL and testbench
==================================

// Module: ascon_perm_iter
// PURPOSE
// - Iterative ASCON permutation engine: applies N rounds (pc->ps->pl) to a 320-bit type_state.
// - Round constant uses round_constant[] from ascon_pack; UNROLL rounds per clock.
// - Sits between the mode FSM (init/AD/plaintext/final) and the state register file;
//   replaces the per-round combinational chain with a start/done pipeline-free datapath.
// PARAMETERS
// - UNROLL  1  rounds per clock; legal values 1 or 2 (elaboration $error otherwise)
// PORTS
// - clock_i     in   1      clock; all logic on rising edge
// - resetb_i    in   1      reset, synchronous, active-low
// - start_i     in   1      request: load state_i and nr_i; accepted only while ready_o=1
// - nr_i        in   4      round count N; 1..12 legal; 0 or >12 treated as 12
// - state_i     in   320    type_state input (5 x 64)
// - ready_o     out  1      engine idle, start_i accepted this cycle
// - done_o      out  1      one-cycle pulse: state_o holds final result
// - state_o     out  320    working/result state register
// BEHAVIOUR
// - Reset: on clock_i edge with resetb_i=0: ready_o=1, done_o=0, state_o=0, round idx=0,
//   FSM=IDLE. Reset mid-operation aborts the permutation; no done_o pulse.
// - FSM: IDLE -> RUN on start_i & ready_o; RUN -> DONE after the last round edge;
//   DONE -> IDLE unconditionally (one cycle). start_i in DONE is ignored.
// - Load edge (E0): state_o<=state_i; idx<=12-N (N after clamp); ready_o<=0.
// - Each RUN edge: applies min(UNROLL, 12-idx) rounds using constants round_constant[idx],
//   round_constant[idx+1]; idx advances by the same count.
// - Odd N with UNROLL=2: final edge applies one round only. Round count is always exactly N.
// - Latency: L=ceil(N/UNROLL) RUN edges; done_o=1 during the cycle after edge E(L),
//   ready_o returns to 1 the cycle after that.
// - pc: x2[7:0]^=constant; ps: 5-bit ASCON S-box per bit column (x0=MSB);
//   pl: x0^=rot19^rot28, x1^=rot61^rot39, x2^=rot1^rot6, x3^=rot10^rot17,
//   x4^=rot7^rot41 (right rotates).
// - state_o intermediate values during RUN are don't-care to consumers. After DONE it holds
//   the result until the next load edge.
// - start_i while ready_o=0: ignored, no queueing. nr_i/state_i sampled only on the load edge.
// CONFIGURATION
// - ASCON_PERM_STATUS_EN defined: adds output port round_o[3:0] = current idx
//   (reset 0, equals 12 in DONE and IDLE after a run).
//   Also adds output busy_err_o, a sticky flag set when start_i is asserted with ready_o=0.
//   The flag is cleared only by reset.
// - ASCON_PERM_STATUS_EN undefined: neither port exists; start-while-busy is silently dropped.
//   Datapath and timing are identical in both builds.
// TESTING
// - Reset: resetb_i=0 for 2 edges mid-run at N=12 -> ready_o=1, done_o=0, state_o=0;
//   no late done pulse.
// - UNROLL=1, N=12, state_i=IV 0x80400c0600000000 then key/nonce=0 -> done_o exactly
//   12 cycles after the load edge; state_o matches the C reference model p12.
// - UNROLL=1, N=6, same input -> done at 6 cycles; constants 0x96..0x4B used
//   (idx 6..11); state_o equals the model p6.
// - UNROLL=2, N=12 and N=8 -> done at 6 and 4 cycles; results bit-identical to the UNROLL=1 run.
// - UNROLL=2, N=1 and nr_i=0 -> N=1 done at 1 cycle, single round 0x4B;
//   nr_i=0 behaves exactly as N=12.
// - Back-to-back: start_i held high throughout -> second load occurs on the edge
//   where ready_o=1. With STATUS_EN, busy_err_o=1 after the first ignored start.

Source files
------------

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation: runs N rounds over a 320-bit state, UNROLL rounds per clock.
// Optional status ports (round_o, busy_err_o) are enabled by defining ASCON_PERM_STATUS_EN.
module ascon_perm_iter #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   nr_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [319:0] state_o
`ifdef ASCON_PERM_STATUS_EN
  ,
  output logic [3:0]   round_o,
  output logic         busy_err_o
`endif
);

  localparam int unsigned SW = 320;
  localparam int unsigned WW = 64;
  localparam int unsigned IW = 4;

  // Padded to 16 entries so idx+1 on the final round never indexes out of range.
  localparam logic [7:0] ROUND_CONSTANT [16] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
  };

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t            st_q, st_n;
  logic [IW-1:0]   idx_q, idx_n, step, nr_c;
  logic [SW-1:0]   state_q, state_n, r1, r2;
  logic            ready_q, ready_n, done_q, done_n;

  function automatic logic [WW-1:0] ror(input logic [WW-1:0] v, input int unsigned r);
    return (v >> r) | (v << (WW - r));
  endfunction

  // One round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [SW-1:0] ascon_round(input logic [SW-1:0] s, input logic [7:0] c);
    logic [WW-1:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ WW'(c);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign nr_c = (nr_i == 4'd0 || nr_i > 4'd12) ? 4'd12 : nr_i;
  assign r1   = ascon_round(state_q, ROUND_CONSTANT[idx_q]);
  assign r2   = ascon_round(r1, ROUND_CONSTANT[idx_q + 4'd1]);
  // Two rounds only when two remain; an odd tail finishes with a single round.
  assign step = (UNROLL == 2 && idx_q < 4'd11) ? 4'd2 : 4'd1;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      st_q    <= IDLE;
      idx_q   <= '0;
      state_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_n;
      idx_q   <= idx_n;
      state_q <= state_n;
      ready_q <= ready_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    st_n    = st_q;
    idx_n   = idx_q;
    state_n = state_q;
    ready_n = ready_q;
    done_n  = 1'b0;
    case (st_q)
      IDLE: begin
        if (start_i && ready_q) begin
          state_n = state_i;
          idx_n   = 4'd12 - nr_c;
          ready_n = 1'b0;
          st_n    = RUN;
        end
      end
      RUN: begin
        state_n = (step == 4'd2) ? r2 : r1;
        idx_n   = idx_q + step;
        if (idx_n == 4'd12) begin
          st_n   = DONE;
          done_n = 1'b1;
        end
      end
      DONE: begin
        ready_n = 1'b1;
        st_n    = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign state_o = state_q;

`ifdef ASCON_PERM_STATUS_EN
  logic busy_err_q;

  // Sticky: a start request arrived while the engine was busy.
  always_ff @(posedge clock_i) begin
    if (!resetb_i)                 busy_err_q <= 1'b0;
    else if (start_i && !ready_q)  busy_err_q <= 1'b1;
  end

  assign round_o    = idx_q;
  assign busy_err_o = busy_err_q;
`endif

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Self-checking bench for ascon_perm_iter: UNROLL=1 and UNROLL=2 instances against a table-driven model.
module tb_ascon_perm_iter;

  localparam bit [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic         clk = 1'b0;
  logic         resetb;
  logic         start [2];
  logic [3:0]   nr [2];
  logic [319:0] st_in [2];
  logic         rdy [2];
  logic         dn [2];
  logic [319:0] st_out [2];
`ifdef ASCON_PERM_STATUS_EN
  logic [3:0]   rnd [2];
  logic         berr [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ascon_perm_iter #(.UNROLL(1)) u_dut1 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start[0]), .nr_i(nr[0]),
    .state_i(st_in[0]), .ready_o(rdy[0]), .done_o(dn[0]), .state_o(st_out[0])
`ifdef ASCON_PERM_STATUS_EN
    , .round_o(rnd[0]), .busy_err_o(berr[0])
`endif
  );

  ascon_perm_iter #(.UNROLL(2)) u_dut2 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start[1]), .nr_i(nr[1]),
    .state_i(st_in[1]), .ready_o(rdy[1]), .done_o(dn[1]), .state_o(st_out[1])
`ifdef ASCON_PERM_STATUS_EN
    , .round_o(rnd[1]), .busy_err_o(berr[1])
`endif
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // Reference permutation: S-box by table lookup per bit column, constants derived arithmetically.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [63:0] x [5];
    logic [4:0]  col, o;
    int          nn;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    nn = (n == 0 || n > 12) ? 12 : n;
    for (int r = 12 - nn; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = SBOX[col];
        for (int i = 0; i < 5; i++) x[i][b] = o[4 - i];
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load one permutation on unit u, measure latency, compare result and handshake.
  task automatic run(input int u, input int n, input logic [319:0] s, output logic [319:0] res);
    int nn, lat, explat, k;
    nn = (n == 0 || n > 12) ? 12 : n;
    explat = (nn + u) / (u + 1);
    k = 0;
    @(negedge clk);
    while (!rdy[u] && k < 50) begin @(negedge clk); k++; end
    start[u] = 1'b1; nr[u] = 4'(n); st_in[u] = s;
    @(posedge clk); #1;
    start[u] = 1'b0; st_in[u] = rand_state();
    check($sformatf("u%0d_n%0d_ready_drop", u, n), 320'(rdy[u]), 320'(0));
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (dn[u]) break;
      @(posedge clk); #1;
      if (dn[u]) lat = c;
    end
    check($sformatf("u%0d_n%0d_latency", u, n), 320'(lat), 320'(explat));
    res = st_out[u];
    check($sformatf("u%0d_n%0d_result", u, n), res, ref_perm(s, n));
`ifdef ASCON_PERM_STATUS_EN
    check($sformatf("u%0d_n%0d_round_done", u, n), 320'(rnd[u]), 320'(12));
`endif
    @(posedge clk); #1;
    check($sformatf("u%0d_n%0d_ready_back", u, n), 320'({rdy[u], dn[u]}), 320'(2'b10));
    check($sformatf("u%0d_n%0d_hold", u, n), st_out[u], res);
  endtask

  logic [319:0] iv, p12a, res, s;
  int pulses, first, second, n;

  initial begin
    iv = {64'h80400c0600000000, 256'h0};
    for (int u = 0; u < 2; u++) begin start[u] = 1'b0; nr[u] = '0; st_in[u] = '0; end
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_u%0d_ctrl", u), 320'({rdy[u], dn[u]}), 320'(2'b10));
      check($sformatf("rst_u%0d_state", u), st_out[u], 320'(0));
`ifdef ASCON_PERM_STATUS_EN
      check($sformatf("rst_u%0d_status", u), 320'({rnd[u], berr[u]}), 320'(0));
`endif
    end
    resetb = 1'b1;

    // Known IV input across both unroll factors.
    run(0, 12, iv, p12a);
    run(0, 6, iv, res);
    run(1, 12, iv, res);
    check("unroll2_matches_unroll1_p12", res, p12a);
    run(1, 8, iv, res);
    run(1, 1, iv, res);
    run(1, 0, iv, res);
    check("nr0_equals_p12", res, p12a);

    // Randomized states and round counts, including out-of-range nr.
    for (int i = 0; i < 6; i++) begin
      s = rand_state();
      n = int'($urandom_range(0, 15));
      run(0, n, s, res);
      run(1, n, s, res);
    end
    run(1, 13, rand_state(), res);
    run(1, 3, rand_state(), res);

    // Reset in the middle of an N=12 run: abort, no late done pulse.
    @(negedge clk);
    start[0] = 1'b1; nr[0] = 4'd12; st_in[0] = rand_state();
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_ctrl", 320'({rdy[0], dn[0]}), 320'(2'b10));
    check("midrst_state", st_out[0], 320'(0));
    resetb = 1'b1;
    pulses = 0;
    repeat (20) begin @(posedge clk); #1; if (dn[0]) pulses++; end
    check("midrst_no_done", 320'(pulses), 320'(0));

    // Back-to-back with start held high on the UNROLL=2 unit, N=2.
`ifdef ASCON_PERM_STATUS_EN
    check("b2b_busy_err_clear", 320'(berr[1]), 320'(0));
`endif
    @(negedge clk);
    s = rand_state();
    start[1] = 1'b1; nr[1] = 4'd2; st_in[1] = s;
    first = 0; second = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (dn[1]) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      if (second != 0) break;
    end
    start[1] = 1'b0;
    check("b2b_first_done", 320'(first), 320'(2));
    check("b2b_spacing", 320'(second - first), 320'(3));
    check("b2b_result", st_out[1], ref_perm(s, 2));
`ifdef ASCON_PERM_STATUS_EN
    check("b2b_busy_err_set", 320'(berr[1]), 320'(1));
`endif
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
